// File: rtl/systolic_psum_drain.sv
// Bottom-of-column partial-sum collector: saturating two-lane accumulation over
// a programmed beat count, results queued in a small show-ahead output FIFO.
module systolic_psum_drain #(
    parameter int unsigned PSUM_DW    = 20,
    parameter int unsigned ACC_DW     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [15:0]           acc_len,
    input  logic [15:0]           tile_len,
    input  logic                  psum_vld,
    input  logic [2*PSUM_DW-1:0]  psum_dat,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [2*ACC_DW-1:0]   out_dat,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf_err,
    output logic                  sat_err
);

    localparam int unsigned LEN_W = 16;
    localparam int unsigned OUT_W = 2 * ACC_DW;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ACC_DW-1:0] ACC_MAX = {1'b0, {(ACC_DW-1){1'b1}}};
    localparam logic [ACC_DW-1:0] ACC_MIN = {1'b1, {(ACC_DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                    state_q, state_nxt;
    logic                      start_tile, beat_en, last_beat, done_nxt;
    logic [LEN_W-1:0]          acc_len_q, tile_len_q, beat_cnt_q, res_cnt_q;
    logic signed [ACC_DW-1:0]  acc_q     [2];
    logic signed [PSUM_DW-1:0] psum_lane [2];
    logic signed [ACC_DW:0]    sum_wide  [2];
    logic signed [ACC_DW-1:0]  lane_res  [2];
    logic [1:0]                lane_sat;
    logic [OUT_W-1:0]          push_dat, head_nxt;
    logic [OUT_W-1:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [CNT_W-1:0]          fifo_cnt_q, fifo_cnt_nxt;
    logic                      pop, full, push_ok, drop;

    // Sign-extended saturating add per lane; one guard bit detects overflow.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            psum_lane[i] = psum_dat[i*PSUM_DW +: PSUM_DW];
            sum_wide[i]  = (ACC_DW+1)'(acc_q[i]) + (ACC_DW+1)'(psum_lane[i]);
            lane_sat[i]  = sum_wide[i][ACC_DW] ^ sum_wide[i][ACC_DW-1];
            if (lane_sat[i]) begin
                lane_res[i] = sum_wide[i][ACC_DW] ? ACC_MIN : ACC_MAX;
            end else begin
                lane_res[i] = sum_wide[i][ACC_DW-1:0];
            end
        end
        push_dat = {lane_res[1], lane_res[0]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        start_tile = 1'b0;
        beat_en    = 1'b0;
        last_beat  = 1'b0;
        done_nxt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_nxt  = RUN;
                    start_tile = 1'b1;
                end
            end
            RUN: begin
                if (psum_vld) begin
                    beat_en = 1'b1;
                    if (beat_cnt_q == acc_len_q - LEN_W'(1)) begin
                        last_beat = 1'b1;
                        if (res_cnt_q == tile_len_q - LEN_W'(1)) begin
                            state_nxt = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (fifo_cnt_q == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO control; a push into a full FIFO survives only if the head leaves.
    always_comb begin
        pop          = out_vld && out_rdy;
        full         = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
        push_ok      = last_beat && (!full || pop);
        drop         = last_beat && full && !pop;
        fifo_cnt_nxt = fifo_cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
        rd_ptr_nxt   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        head_nxt     = (push_ok && (wr_ptr_q == rd_ptr_nxt)) ? push_dat : mem[rd_ptr_nxt];
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q[0]   <= '0;
            acc_q[1]   <= '0;
            acc_len_q  <= '0;
            tile_len_q <= '0;
            beat_cnt_q <= '0;
            res_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            out_vld    <= 1'b0;
            out_dat    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ovf_err    <= 1'b0;
            sat_err    <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            done <= done_nxt;
            if (start_tile) begin
                acc_q[0]   <= '0;
                acc_q[1]   <= '0;
                beat_cnt_q <= '0;
                res_cnt_q  <= '0;
                acc_len_q  <= (acc_len == '0) ? LEN_W'(1) : acc_len;
                tile_len_q <= (tile_len == '0) ? LEN_W'(1) : tile_len;
                ovf_err    <= 1'b0;
                sat_err    <= 1'b0;
            end else if (beat_en) begin
                if (last_beat) begin
                    acc_q[0]   <= '0;
                    acc_q[1]   <= '0;
                    beat_cnt_q <= '0;
                    res_cnt_q  <= res_cnt_q + LEN_W'(1);
                end else begin
                    acc_q[0]   <= lane_res[0];
                    acc_q[1]   <= lane_res[1];
                    beat_cnt_q <= beat_cnt_q + LEN_W'(1);
                end
                if (|lane_sat) begin
                    sat_err <= 1'b1;
                end
                if (drop) begin
                    ovf_err <= 1'b1;
                end
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            rd_ptr_q   <= rd_ptr_nxt;
            fifo_cnt_q <= fifo_cnt_nxt;
            out_vld    <= (fifo_cnt_nxt != '0);
            out_dat    <= head_nxt;
        end
    end

endmodule
